// File: rtl/platform_collision.sv
// platform_collision: per-frame landing detector for the doodle against 8 platforms.
// On a new-frame edge it snapshots the doodle and platform coordinates. It then
// scans one platform per cycle and reports the landing target in a final cycle.
// Optional feature macro: PLATFORM_COLLISION_NEAREST_EN. When it is defined,
// the highest qualifying platform (smallest Y) wins, and ties go to the lower index.
// When it is undefined, the first qualifying platform in scan order wins.
module platform_collision #(
    parameter int PLAT_W   = 60,
    parameter int DOODLE_W = 40,
    parameter int DOODLE_H = 40,
    parameter int LAND_TOL = 6,
    parameter int N_PLAT   = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] frame_clk_edge,
    input  logic       enable,
    input  logic [9:0] Doodle_X,
    input  logic [9:0] Doodle_Y,
    input  logic [9:0] Doodle_Y_motion,
    input  logic [9:0] Platform_X_in [0:N_PLAT-1],
    input  logic [9:0] Platform_Y_in [0:N_PLAT-1],
    output logic       land,
    output logic [2:0] land_idx,
    output logic [9:0] land_y,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REPORT
    } state_t;

    // Geometry constants widened to 11 bits so that sums near the screen edge cannot wrap.
    localparam logic [10:0] PW11  = 11'(PLAT_W);
    localparam logic [10:0] DW11  = 11'(DOODLE_W);
    localparam logic [10:0] DH11  = 11'(DOODLE_H);
    localparam logic [10:0] TOL11 = 11'(LAND_TOL);
    localparam logic [9:0]  DH10  = 10'(DOODLE_H);
    localparam logic [2:0]  LAST  = 3'(N_PLAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        hit_q, hit_d;
    logic [2:0]  hit_idx_q, hit_idx_d;
    logic [9:0]  hit_py_q, hit_py_d;
    logic        land_q, land_d;
    logic [2:0]  land_idx_q, land_idx_d;
    logic [9:0]  land_y_q, land_y_d;
    logic        capture;

    // Frozen copy of this frame's coordinates, taken as the FSM leaves IDLE.
    logic [9:0]  dx_q, dy_q, dm_q;
    logic [9:0]  px_q [0:N_PLAT-1];
    logic [9:0]  py_q [0:N_PLAT-1];

    logic        new_frame;
    logic [9:0]  cur_px, cur_py;
    logic [10:0] feet;
    logic        falling, h_ovl, v_win, qualify, take;

    assign new_frame = (frame_clk_edge == 2'b01);

    assign cur_px  = px_q[idx_q];
    assign cur_py  = py_q[idx_q];
    assign feet    = {1'b0, dy_q} + DH11;
    assign falling = !dm_q[9] && (dm_q != 10'd0);
    assign h_ovl   = (({1'b0, dx_q} + DW11) > {1'b0, cur_px}) &&
                     ({1'b0, dx_q} < ({1'b0, cur_px} + PW11));
    assign v_win   = ({1'b0, cur_py} <= feet) && (feet <= ({1'b0, cur_py} + TOL11));
    assign qualify = falling && h_ovl && v_win;

`ifdef PLATFORM_COLLISION_NEAREST_EN
    // A strictly smaller Y replaces the current winner, so an equal Y keeps the lower index.
    assign take = qualify && (!hit_q || (cur_py < hit_py_q));
`else
    // The first qualifying platform is kept, and later hits never overwrite it.
    assign take = qualify && !hit_q;
`endif

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state, scan bookkeeping and report values.
    always_comb begin
        // NOTE: every target gets a default first, so that no path can infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        hit_py_d   = hit_py_q;
        land_d     = 1'b0;
        land_idx_d = land_idx_q;
        land_y_d   = land_y_q;
        capture    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (new_frame && enable) begin
                    state_d = S_SCAN;
                    idx_d   = 3'd0;
                    hit_d   = 1'b0;
                    capture = 1'b1;
                end
            end
            S_SCAN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    if (take) begin
                        hit_d     = 1'b1;
                        hit_idx_d = idx_q;
                        hit_py_d  = cur_py;
                    end
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST) begin
                        state_d = S_REPORT;
                        // Report values are registered here so that they appear exactly in the REPORT cycle.
                        if (hit_d) begin
                            land_d     = 1'b1;
                            land_idx_d = hit_idx_d;
                            land_y_d   = (hit_py_d >= DH10) ? (hit_py_d - DH10) : 10'd0;
                        end
                    end
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Snapshot of the doodle and platform coordinates.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dx_q <= '0;
            dy_q <= '0;
            dm_q <= '0;
            // NOTE: these arrays are reset on purpose so that a scan never sees stale data after reset.
            for (int i = 0; i < N_PLAT; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else if (capture) begin
            dx_q <= Doodle_X;
            dy_q <= Doodle_Y;
            dm_q <= Doodle_Y_motion;
            for (int i = 0; i < N_PLAT; i++) begin
                px_q[i] <= Platform_X_in[i];
                py_q[i] <= Platform_Y_in[i];
            end
        end
    end

    // Scan index, hit tracking and reported landing results.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx_q      <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            hit_py_q   <= '0;
            land_q     <= 1'b0;
            land_idx_q <= '0;
            land_y_q   <= '0;
        end else begin
            idx_q      <= idx_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            hit_py_q   <= hit_py_d;
            land_q     <= land_d;
            land_idx_q <= land_idx_d;
            land_y_q   <= land_y_d;
        end
    end

    assign land     = land_q;
    assign land_idx = land_idx_q;
    assign land_y   = land_y_q;
    assign busy     = (state_q != S_IDLE);
    assign overrun  = busy && new_frame;

endmodule
